reg_cmd_ctrl: RTL
=================

Name: reg_cmd_ctrl

Overview:
Command front-end feeding the register file. It consumes bytes from the UART receiver, decodes write and read frames, and drives the register file WrEn/RdEn/Address/WrData strobes. For reads it captures RdData when RdData_Valid arrives and pushes the byte to the UART transmit FIFO. Inter-byte and read-response timeouts abort a stalled frame back to idle.

Parameters:
ADDRESS_WIDTH, 4, register file address width; the legal range is 0 .. 2**ADDRESS_WIDTH-1.
DATA_WIDTH, 8, byte width of the UART data and the register file data.
TIMEOUT_CYCLES, 1024, clock cycles allowed between operand bytes, and for the read response, before the frame is aborted.

Ports:
CLK  in  1  system clock, rising edge.
RST  in  1  asynchronous, active-high reset.
RX_P_DATA  in  DATA_WIDTH  received UART byte.
RX_D_VLD  in  1  one-cycle strobe; RX_P_DATA is valid in that cycle.
RdData  in  DATA_WIDTH  register file read data.
RdData_Valid  in  1  register file read-data strobe.
TX_FULL  in  1  transmit FIFO full; a push is not allowed while high.
WrEn  out  1  register file write strobe.
RdEn  out  1  register file read strobe.
Address  out  ADDRESS_WIDTH  register file address.
WrData  out  DATA_WIDTH  register file write data.
TX_P_DATA  out  DATA_WIDTH  byte to push into the transmit FIFO.
TX_D_VLD  out  1  transmit FIFO push strobe.
Busy  out  1  high in any state other than IDLE.
Err_Pulse  out  1  one-cycle error strobe.
Err_Code  out  2  error cause, meaningful only when Err_Pulse=1: 00 overrun, 01 bad opcode, 10 bad address, 11 timeout.

Behaviour:
- All outputs are registered. Reset value of every output is 0. The FSM resets to IDLE and the timeout counter resets to 0.
- Opcodes: 0xAA = write frame {0xAA, addr, data}; 0xBB = read frame {0xBB, addr}.
- IDLE:
  - RX 0xAA -> WR_ADDR.
  - RX 0xBB -> RD_ADDR.
  - RX of any other byte -> stay in IDLE; Err_Pulse=1, Err_Code=01.
- WR_ADDR / RD_ADDR, on RX:
  - If addr[7:ADDRESS_WIDTH] != 0 -> IDLE; Err_Pulse=1, Err_Code=10.
  - Otherwise latch Address and go to WR_DATA (from WR_ADDR) or RD_REQ (from RD_ADDR).
- After a bad-address abort, the next byte is treated as a new opcode.
- WR_DATA, on RX: in the next cycle WrEn=1 for exactly 1 cycle and WrData=the byte; then IDLE. Address stays stable while WrEn is high.
- RD_REQ: RdEn=1 for exactly 1 cycle, then RD_WAIT.
- RD_WAIT: on RdData_Valid, capture RdData into TX_P_DATA and go to TX_PUSH.
- TX_PUSH: when TX_FULL=0, TX_D_VLD=1 for exactly 1 cycle, then IDLE. While TX_FULL=1, hold TX_P_DATA and wait; no timeout applies in TX_PUSH.
- WrEn and RdEn are never high together.
- Timeout:
  - The counter is cleared on entry to WR_ADDR, RD_ADDR, WR_DATA and RD_WAIT, and on every accepted RX byte.
  - It increments in those states.
  - At TIMEOUT_CYCLES-1 the FSM goes to IDLE with Err_Pulse=1, Err_Code=11, and no WrEn/RdEn is issued.
- Overrun: an RX_D_VLD during RD_REQ, RD_WAIT or TX_PUSH drops the byte; Err_Pulse=1, Err_Code=00, state unchanged.
- Latency:
  - Write: last RX byte -> WrEn high in the next cycle.
  - Read: addr byte -> RdEn at +1; TX_D_VLD one cycle after RdData_Valid when TX_FULL=0.
- Reset asserted mid-frame: all strobes drop immediately (asynchronously) and the partial frame is discarded.

Decomposition:
- Package reg_cmd_pkg:
  - opcode constants OPC_WRITE=0xAA and OPC_READ=0xBB;
  - state enum {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_REQ, RD_WAIT, TX_PUSH};
  - Err_Code constants ERR_OVERRUN, ERR_OPCODE, ERR_ADDR, ERR_TIMEOUT.
- One sub-module, reg_cmd_timeout: clearable saturating counter with a TIMEOUT_CYCLES parameter and an expire output. The FSM stays in the top module.

Test Plan:
- Write: RX 0xAA, 0x05, 0x3C -> a single WrEn pulse with Address=5, WrData=0x3C; RdEn stays 0; Busy returns to 0.
- Read: RX 0xBB, 0x02 with a register file model answering 0x20 one cycle after RdEn -> one RdEn pulse with Address=2; TX_D_VLD=1 with TX_P_DATA=0x20.
- Back-pressure: same read with TX_FULL held for 5 cycles after RdData_Valid -> TX_D_VLD stays 0 for those cycles, then fires once with 0x20; no error.
- Errors:
  - RX 0x11 -> Err_Code=01.
  - RX 0xAA, 0x1F -> Err_Code=10 and no WrEn.
  - A following 0xBB, 0x01 read completes normally.
- Timeout / overrun:
  - RX 0xAA, 0x03, then silence for TIMEOUT_CYCLES -> Err_Code=11, no WrEn, state IDLE.
  - An RX byte during RD_WAIT -> Err_Code=00 and the read still completes.
- Reset: assert RST in WR_DATA -> all outputs 0 at once; after release, RX 0x44 alone gives Err_Code=01 (a fresh frame).

Source files
------------

// File: rtl/reg_cmd_pkg.sv
// reg_cmd_pkg: opcodes, FSM states and error codes shared by the command front-end
package reg_cmd_pkg;
  localparam logic [7:0] OPC_WRITE = 8'hAA;
  localparam logic [7:0] OPC_READ  = 8'hBB;
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_REQ, RD_WAIT, TX_PUSH} state_t;
  localparam logic [1:0] ERR_OVERRUN = 2'b00;
  localparam logic [1:0] ERR_OPCODE  = 2'b01;
  localparam logic [1:0] ERR_ADDR    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;
endpackage

// File: rtl/reg_cmd_timeout.sv
// reg_cmd_timeout: clearable saturating counter; expire_o while enabled and at TIMEOUT_CYCLES-1 (clk, rst, clr_i, en_i -> expire_o)
module reg_cmd_timeout #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int W = TIMEOUT_CYCLES > 2 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i && cnt_q != LAST) cnt_q <= cnt_q + W'(1);
  assign expire_o = en_i && cnt_q == LAST;
endmodule

// File: rtl/reg_cmd_ctrl.sv
// reg_cmd_ctrl: UART frame decoder (RX_P_DATA/RX_D_VLD in) driving register file WrEn/RdEn/Address/WrData, returning RdData via TX_P_DATA/TX_D_VLD, with Busy and Err_Pulse/Err_Code status
module reg_cmd_ctrl
  import reg_cmd_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]    RdData,
  input  logic                     RdData_Valid,
  input  logic                     TX_FULL,
  output logic                     WrEn,
  output logic                     RdEn,
  output logic [ADDRESS_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0]    WrData,
  output logic [DATA_WIDTH-1:0]    TX_P_DATA,
  output logic                     TX_D_VLD,
  output logic                     Busy,
  output logic                     Err_Pulse,
  output logic [1:0]               Err_Code
);
  state_t state_q;
  logic rx_take, bad_addr, expire, resp;
  assign rx_take  = RX_D_VLD && state_q inside {IDLE, WR_ADDR, WR_DATA, RD_ADDR};
  assign bad_addr = |(RX_P_DATA >> ADDRESS_WIDTH);
  // the event that keeps a timed state alive this cycle
  assign resp     = state_q == RD_WAIT ? RdData_Valid : RX_D_VLD;
  reg_cmd_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (CLK),
    .rst     (RST),
    .clr_i   (rx_take || state_q == RD_REQ),
    .en_i    (state_q inside {WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT}),
    .expire_o(expire)
  );
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q   <= IDLE;
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      Address   <= '0;
      WrData    <= '0;
      TX_P_DATA <= '0;
      TX_D_VLD  <= 1'b0;
      Busy      <= 1'b0;
      Err_Pulse <= 1'b0;
      Err_Code  <= '0;
    end else begin
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      TX_D_VLD  <= 1'b0;
      Err_Pulse <= 1'b0;
      if (RX_D_VLD && !rx_take) begin
        Err_Pulse <= 1'b1;
        Err_Code  <= ERR_OVERRUN;
      end
      case (state_q)
        IDLE: if (RX_D_VLD) begin
          if (RX_P_DATA == DATA_WIDTH'(OPC_WRITE) || RX_P_DATA == DATA_WIDTH'(OPC_READ)) begin
            state_q <= RX_P_DATA == DATA_WIDTH'(OPC_WRITE) ? WR_ADDR : RD_ADDR;
            Busy    <= 1'b1;
          end else begin
            Err_Pulse <= 1'b1;
            Err_Code  <= ERR_OPCODE;
          end
        end
        WR_ADDR, RD_ADDR: if (RX_D_VLD) begin
          if (bad_addr) begin
            state_q   <= IDLE;
            Busy      <= 1'b0;
            Err_Pulse <= 1'b1;
            Err_Code  <= ERR_ADDR;
          end else begin
            Address <= RX_P_DATA[ADDRESS_WIDTH-1:0];
            RdEn    <= state_q == RD_ADDR;
            state_q <= state_q == RD_ADDR ? RD_REQ : WR_DATA;
          end
        end
        WR_DATA: if (RX_D_VLD) begin
          WrEn    <= 1'b1;
          WrData  <= RX_P_DATA;
          state_q <= IDLE;
          Busy    <= 1'b0;
        end
        RD_REQ: state_q <= RD_WAIT;
        RD_WAIT: if (RdData_Valid) begin
          TX_P_DATA <= RdData;
          TX_D_VLD  <= !TX_FULL;
          state_q   <= TX_FULL ? TX_PUSH : IDLE;
          Busy      <= TX_FULL;
        end
        TX_PUSH: if (!TX_FULL) begin
          TX_D_VLD <= 1'b1;
          state_q  <= IDLE;
          Busy     <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          Busy    <= 1'b0;
        end
      endcase
      // a timeout outranks an overrun reported in the same cycle
      if (expire && !resp) begin
        state_q   <= IDLE;
        Busy      <= 1'b0;
        Err_Pulse <= 1'b1;
        Err_Code  <= ERR_TIMEOUT;
      end
    end
endmodule
